// File: rtl/sram_arb.sv
// rtl/sram_arb.sv - two-requester SRAM issue arbiter with read-return routing FIFO
module sram_arb #(
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        m0_req,
  input  logic        m0_rd,
  input  logic [17:0] m0_addr,
  input  logic [1:0]  m0_be,
  input  logic [15:0] m0_wr_data,
  output logic        m0_ready,
  output logic        m0_rd_data_vld,
  output logic [15:0] m0_rd_data,
  input  logic        m1_req,
  input  logic        m1_rd,
  input  logic [17:0] m1_addr,
  input  logic [1:0]  m1_be,
  input  logic [15:0] m1_wr_data,
  output logic        m1_ready,
  output logic        m1_rd_data_vld,
  output logic [15:0] m1_rd_data,
  output logic        sram_req,
  input  logic        sram_ready,
  output logic        sram_rd,
  output logic [17:0] sram_addr,
  output logic [1:0]  sram_be,
  output logic [15:0] sram_wr_data,
  input  logic        sram_rd_data_vld,
  input  logic [15:0] sram_rd_data,
  output logic        rd_orphan_err
);

  localparam int AW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(RD_FIFO_DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RD_FIFO_DEPTH);

  logic          prio;
  logic          id_mem [RD_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic fifo_full;
  logic fifo_empty;
  logic elig0;
  logic elig1;
  logic grant;
  logic accept;
  logic push;
  logic pop;
  logic head_id;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);

  // Full is the pre-pop view, so a same-cycle return never frees a slot for a new read.
  assign elig0 = m0_req & (~m0_rd | ~fifo_full);
  assign elig1 = m1_req & (~m1_rd | ~fifo_full);

  assign sram_req = elig0 | elig1;

  always_comb begin
    grant = 1'b0;
    if (elig0 && elig1) begin
      grant = prio;
    end else if (elig1) begin
      grant = 1'b1;
    end
  end

  assign sram_rd      = grant ? m1_rd      : m0_rd;
  assign sram_addr    = grant ? m1_addr    : m0_addr;
  assign sram_be      = grant ? m1_be      : m0_be;
  assign sram_wr_data = grant ? m1_wr_data : m0_wr_data;

  assign accept   = sram_req & sram_ready;
  assign m0_ready = accept & ~grant;
  assign m1_ready = accept & grant;

  assign push    = accept & sram_rd;
  assign pop     = sram_rd_data_vld & ~fifo_empty;
  assign head_id = id_mem[rd_ptr];

  assign m0_rd_data_vld = pop & ~head_id;
  assign m1_rd_data_vld = pop & head_id;
  assign m0_rd_data     = sram_rd_data;
  assign m1_rd_data     = sram_rd_data;

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr] <= grant;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      prio          <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_orphan_err <= 1'b0;
    end else begin
      if (accept) begin
        prio <= ~grant;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (sram_rd_data_vld && fifo_empty) begin
        rd_orphan_err <= 1'b1;
      end
    end
  end

endmodule
